// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch PC controller: next-PC select codes,
// reset/exception vectors and the fetch FSM state encoding.
package pc_ctrl_pkg;

   localparam logic [3:0] NPC_PC4 = 4'd0;
   localparam logic [3:0] NPC_BEQ = 4'd1;
   localparam logic [3:0] NPC_J   = 4'd2;
   localparam logic [3:0] NPC_JAL = 4'd3;
   localparam logic [3:0] NPC_JR  = 4'd4;

   localparam logic [31:0] RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } pc_state_e;

endpackage

// File: rtl/pc_target.sv
// Redirect decision and target address for a control transfer resolved in decode.
module pc_target
   import pc_ctrl_pkg::*;
(
   input  logic        id_valid,
   input  logic [31:0] id_pc,
   input  logic [3:0]  npc_sel,
   input  logic        cmp_eq,
   input  logic [15:0] imm16,
   input  logic [25:0] addr26,
   input  logic [31:0] jr_target,
   output logic        redirect,
   output logic [31:0] target
);

   always_comb begin
      redirect = id_valid && (npc_sel != NPC_PC4) && ((npc_sel != NPC_BEQ) || cmp_eq);
      case (npc_sel)
         NPC_BEQ:        target = id_pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
         NPC_J, NPC_JAL: target = {id_pc[31:28], addr26, 2'b00};
         NPC_JR:         target = jr_target;
         default:        target = id_pc + 32'd4;
      endcase
   end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch PC controller: sequential fetch, stall hold, delayed-branch redirect with squash.
// Optional exception/eret support is built when PC_CTRL_EXC_EN is defined.
//
// state | meaning
// IDLE  | one cycle after reset release, no fetch
// FETCH | requesting imem at pc
// HOLD  | delivered word stalled downstream, no request
module pc_ctrl
   import pc_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [31:0] id_pc,
   input  logic [3:0]  npc_sel,
   input  logic        cmp_eq,
   input  logic [15:0] imm16,
   input  logic [25:0] addr26,
   input  logic [31:0] jr_target,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
`ifdef PC_CTRL_EXC_EN
   input  logic        exc_req,
   input  logic        eret,
   input  logic [31:0] epc,
`endif
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc
);

   pc_state_e   state, state_nxt;
   logic [31:0] pc;
   logic [31:0] tgt_q;
   logic        squash;
   logic        dec_redirect;
   logic [31:0] dec_target;
   logic        redir;
   logic [31:0] redir_pc;
   logic        exc_take;
   logic        take_redir;
   logic        accept;

   pc_target u_target (
      .id_valid  (id_valid),
      .id_pc     (id_pc),
      .npc_sel   (npc_sel),
      .cmp_eq    (cmp_eq),
      .imm16     (imm16),
      .addr26    (addr26),
      .jr_target (jr_target),
      .redirect  (dec_redirect),
      .target    (dec_target)
   );

`ifdef PC_CTRL_EXC_EN
   assign exc_take = exc_req;
   assign redir    = eret || dec_redirect;
   assign redir_pc = eret ? epc : dec_target;
`else
   assign exc_take = 1'b0;
   assign redir    = dec_redirect;
   assign redir_pc = dec_target;
`endif

   // A redirect arriving while a squash is pending is dropped.
   assign take_redir = redir && !squash;
   assign accept     = imem_req && imem_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  state_nxt = ST_FETCH;
         ST_FETCH: if (if_valid && stall && !exc_take) state_nxt = ST_HOLD;
         ST_HOLD:  if (!stall || exc_take) state_nxt = ST_FETCH;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      imem_req  = (state == ST_FETCH) && !(if_valid && stall);
      imem_addr = pc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         tgt_q    <= RESET_PC;
         squash   <= 1'b0;
         if_valid <= 1'b0;
         if_instr <= 32'd0;
         if_pc    <= 32'd0;
      end else if (exc_take) begin
         pc       <= EXC_VECTOR;
         squash   <= 1'b0;
         if_valid <= 1'b0;
      end else begin
         if (accept && !squash && !take_redir) begin
            if_valid <= 1'b1;
            if_instr <= imem_rdata;
            if_pc    <= pc;
         end else if (if_valid && !stall) begin
            if_valid <= 1'b0;
         end

         // Outstanding fetch of the wrong path must finish before pc moves.
         if (squash) begin
            if (accept) begin
               pc     <= tgt_q;
               squash <= 1'b0;
            end
         end else if (take_redir) begin
            if (accept || !imem_req) begin
               pc <= redir_pc;
            end else begin
               squash <= 1'b1;
               tgt_q  <= redir_pc;
            end
         end else if (accept) begin
            pc <= pc + 32'd4;
         end
      end
   end

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: expected delivered PCs are queued per scenario
// and popped as the design hands instructions downstream.
module tb_pc_ctrl;
   import pc_ctrl_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [3:0]  npc_sel;
   logic        cmp_eq;
   logic [15:0] imm16;
   logic [25:0] addr26;
   logic [31:0] jr_target;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
`ifdef PC_CTRL_EXC_EN
   logic        exc_req;
   logic        eret;
   logic [31:0] epc;
`endif

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] sb_q[$];
   logic [31:0] mon_exp;
   bit          mon_en = 0;
   int          mem_lat = 0;
   int          mem_wait = 0;

   pc_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .id_valid   (id_valid),
      .id_pc      (id_pc),
      .npc_sel    (npc_sel),
      .cmp_eq     (cmp_eq),
      .imm16      (imm16),
      .addr26     (addr26),
      .jr_target  (jr_target),
      .stall      (stall),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
`ifdef PC_CTRL_EXC_EN
      .exc_req    (exc_req),
      .eret       (eret),
      .epc        (epc),
`endif
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .if_pc      (if_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Instruction memory: answers each request after mem_lat wait cycles.
   always @(negedge clk) begin
      if (!rst_n || !imem_req) begin
         imem_ready = 1'b0;
         mem_wait   = 0;
      end else if (mem_wait >= mem_lat) begin
         imem_ready = 1'b1;
         imem_rdata = mem_word(imem_addr);
         mem_wait   = 0;
      end else begin
         imem_ready = 1'b0;
         mem_wait++;
      end
   end

   always @(negedge clk) begin
      if (mon_en && rst_n && if_valid && !stall && sb_q.size() != 0) begin
         mon_exp = sb_q.pop_front();
         chk("if_pc", if_pc, mon_exp);
         chk("if_instr", if_instr, mem_word(mon_exp));
      end
   end

   task automatic do_reset(input int lat);
      mon_en = 0;
      sb_q.delete();
      mem_lat = lat;
      stall = 1'b0;
      id_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_ifv", {31'd0, if_valid}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0000_3000);
      chk("rst_ifpc", if_pc, 32'd0);
      chk("rst_instr", if_instr, 32'd0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      mon_en = 1;
   endtask

   task automatic wait_fetch(input logic [31:0] a, input string tag);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (imem_req && imem_addr == a) return;
      end
      chk(tag, imem_req ? imem_addr : 32'hFFFF_FFFF, a);
   endtask

   task automatic next_fetch(input logic [31:0] skip, input logic [31:0] exp, input string tag);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (imem_req && imem_addr != skip) break;
      end
      chk(tag, imem_req ? imem_addr : 32'hFFFF_FFFF, exp);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (sb_q.size() == 0) break;
      end
      chk(tag, 32'(sb_q.size()), 32'd0);
      mon_en = 0;
   endtask

   task automatic redirect(input logic [3:0] sel, input logic [31:0] ipc, input logic ceq,
                           input logic [15:0] imm, input logic [25:0] a26, input logic [31:0] jr);
      id_valid  = 1'b1;
      npc_sel   = sel;
      id_pc     = ipc;
      cmp_eq    = ceq;
      imm16     = imm;
      addr26    = a26;
      jr_target = jr;
      @(posedge clk);
      #1 id_valid = 1'b0;
      npc_sel = NPC_PC4;
      cmp_eq  = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; id_valid = 1'b0; id_pc = 32'd0; npc_sel = NPC_PC4; cmp_eq = 1'b0;
      imm16 = 16'd0; addr26 = 26'd0; jr_target = 32'd0; stall = 1'b0;
      imem_ready = 1'b0; imem_rdata = 32'd0;
`ifdef PC_CTRL_EXC_EN
      exc_req = 1'b0; eret = 1'b0; epc = 32'd0;
`endif

      // Sequential fetch, ready every cycle
      do_reset(0);
      sb_q = '{32'h3000, 32'h3004, 32'h3008, 32'h300C};
      @(negedge clk); chk("s1_idle_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk); chk("s1_addr0", imem_addr, 32'h3000);
      chk("s1_req", {31'd0, imem_req}, 32'd1);
      @(negedge clk); chk("s1_addr1", imem_addr, 32'h3004); chk("s1_ifpc0", if_pc, 32'h3000);
      @(negedge clk); chk("s1_addr2", imem_addr, 32'h3008); chk("s1_ifpc1", if_pc, 32'h3004);
      drain("s1_drain");

      // Stall holds the delivered word, fetch resumes at the next address
      do_reset(0);
      sb_q = '{32'h3000, 32'h3004, 32'h3008, 32'h300C};
      wait_fetch(32'h3008, "s2_wait");
      @(posedge clk); #1 stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("s2_req", {31'd0, imem_req}, 32'd0);
         chk("s2_ifpc", if_pc, 32'h3008);
         chk("s2_ifv", {31'd0, if_valid}, 32'd1);
      end
      @(posedge clk); #1 stall = 1'b0;
      next_fetch(32'hFFFF_FFFF, 32'h300C, "s2_resume");
      drain("s2_drain");

      // Taken BEQ with fetch of id_pc+8 outstanding: squash
      do_reset(3);
      sb_q = '{32'h3000, 32'h3004, 32'h3014, 32'h3018};
      wait_fetch(32'h3008, "s3_wait");
      redirect(NPC_BEQ, 32'h3000, 1'b1, 16'h0004, 26'd0, 32'd0);
      next_fetch(32'h3008, 32'h3014, "s3_target");
      drain("s3_drain");

      // JR in the same cycle the id_pc+8 word lands
      do_reset(0);
      sb_q = '{32'h3000, 32'h3004, 32'h3100, 32'h3104};
      wait_fetch(32'h3008, "s4_wait");
      redirect(NPC_JR, 32'h3000, 1'b0, 16'd0, 26'd0, 32'h0000_3100);
      next_fetch(32'h3008, 32'h3100, "s4_target");
      drain("s4_drain");

      // BEQ not taken
      do_reset(0);
      sb_q = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010};
      wait_fetch(32'h3008, "s5_wait");
      redirect(NPC_BEQ, 32'h3000, 1'b0, 16'h0004, 26'd0, 32'd0);
      next_fetch(32'h3008, 32'h300C, "s5_seq");
      drain("s5_drain");

      // Backward BEQ (negative offset)
      do_reset(0);
      sb_q = '{32'h3000, 32'h3004, 32'h2FF4, 32'h2FF8};
      wait_fetch(32'h3008, "s6_wait");
      redirect(NPC_BEQ, 32'h3000, 1'b1, 16'hFFFC, 26'd0, 32'd0);
      next_fetch(32'h3008, 32'h2FF4, "s6_target");
      drain("s6_drain");

      // J while held: no request outstanding, pc takes target directly
      do_reset(0);
      sb_q = '{32'h3000, 32'h3004, 32'h3008, 32'h3200};
      wait_fetch(32'h3008, "s7_wait");
      @(posedge clk); #1 stall = 1'b1;
      @(negedge clk); chk("s7_req", {31'd0, imem_req}, 32'd0);
      redirect(NPC_J, 32'h3004, 1'b0, 16'd0, 26'h0000C80, 32'd0);
      @(negedge clk); chk("s7_ifpc", if_pc, 32'h3008);
      @(posedge clk); #1 stall = 1'b0;
      next_fetch(32'hFFFF_FFFF, 32'h3200, "s7_target");
      drain("s7_drain");

      // Reset in the middle of an outstanding fetch
      do_reset(3);
      wait_fetch(32'h3004, "s8_wait");
      do_reset(3);
      sb_q = '{32'h3000, 32'h3004};
      drain("s8_drain");

`ifdef PC_CTRL_EXC_EN
      // Exception during outstanding fetch, then eret
      do_reset(3);
      sb_q = '{32'h3000, 32'h3004, 32'h4180, 32'h3010};
      wait_fetch(32'h3008, "s9_wait");
      exc_req = 1'b1;
      @(posedge clk); #1 exc_req = 1'b0;
      @(negedge clk);
      chk("s9_ifv", {31'd0, if_valid}, 32'd0);
      chk("s9_vec", imem_addr, 32'h4180);
      wait_fetch(32'h4184, "s9_wait2");
      eret = 1'b1; epc = 32'h3010;
      @(posedge clk); #1 eret = 1'b0;
      next_fetch(32'h4184, 32'h3010, "s9_eret");
      drain("s9_drain");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
